// File: rtl/cache_axi_line_fill_if.sv
// AXI4 read-address and read-data channels between the line-fill engine and the interconnect.
interface cache_axi_line_fill_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 1
) ();
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic [ID_W-1:0]   arid;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/cache_axi_line_fill.sv
// Cache line refill: one AXI4 read burst per replacement request, each beat streamed into the line.
// state | meaning
// IDLE  | waiting for a refill request
// ADDR  | presenting the burst on AR
// DATA  | accepting beats until rlast
module cache_axi_line_fill #(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int BE_ADDR_W  = FE_ADDR_W,
   parameter int BE_DATA_W  = 32,
   parameter int WORD_OFF_W = 3,
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ID     = 0,
   parameter int WRAP_EN    = 0,
   localparam int BE_BYTE_W   = $clog2(BE_DATA_W/8),
   localparam int LINE2MEM_W  = WORD_OFF_W - $clog2(BE_DATA_W/FE_DATA_W),
   localparam int LINE_ADDR_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   replace_valid_i,
   input  logic [LINE_ADDR_W-1:0] replace_addr_i,
   input  logic [LINE2MEM_W-1:0]  replace_word_i,
   output logic                   replace_o,
   output logic                   read_valid_o,
   output logic [LINE2MEM_W-1:0]  read_addr_o,
   output logic [BE_DATA_W-1:0]   read_rdata_o,
   output logic                   rd_err_o,
   input  logic                   err_clr_i,
   cache_axi_line_fill_if.master  axi
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   localparam int BEATS = 1 << LINE2MEM_W;
   localparam logic [LINE2MEM_W:0] BEATS_C = BEATS[LINE2MEM_W:0];
   localparam logic [LINE2MEM_W:0] LAST_C  = BEATS_C - 1'b1;

   state_t                   state_q, state_d;
   logic [LINE_ADDR_W-1:0]   line_addr_q, line_addr_d;
   logic [LINE2MEM_W-1:0]    start_beat_q, start_beat_d;
   logic [LINE2MEM_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [LINE2MEM_W:0]      rcv_cnt_q, rcv_cnt_d;
   logic                     rd_err_q, rd_err_d;
   logic                     err_set;
   logic [FE_ADDR_W-1:0]     araddr_full;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         line_addr_q  <= '0;
         start_beat_q <= '0;
         beat_cnt_q   <= '0;
         rcv_cnt_q    <= '0;
         rd_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_addr_q  <= line_addr_d;
         start_beat_q <= start_beat_d;
         beat_cnt_q   <= beat_cnt_d;
         rcv_cnt_q    <= rcv_cnt_d;
         rd_err_q     <= rd_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      line_addr_d  = line_addr_q;
      start_beat_d = start_beat_q;
      beat_cnt_d   = beat_cnt_q;
      rcv_cnt_d    = rcv_cnt_q;
      err_set      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (replace_valid_i) begin
               line_addr_d  = replace_addr_i;
               start_beat_d = (WRAP_EN != 0) ? replace_word_i : '0;
               state_d      = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (axi.arready) begin
               beat_cnt_d = start_beat_q;
               rcv_cnt_d  = '0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (axi.rvalid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               // count saturates one past the line so overrun beats stay dropped
               if (rcv_cnt_q != BEATS_C) rcv_cnt_d = rcv_cnt_q + 1'b1;
               if (axi.rresp != 2'b00) err_set = 1'b1;
               if (axi.rlast && (rcv_cnt_q != LAST_C)) err_set = 1'b1;
               if (!axi.rlast && (rcv_cnt_q == BEATS_C)) err_set = 1'b1;
               if (axi.rlast) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_err_d = err_set | (rd_err_q & ~err_clr_i);
   end

   assign replace_o    = (state_q != ST_IDLE);
   assign read_valid_o = (state_q == ST_DATA) && axi.rvalid && (rcv_cnt_q < BEATS_C);
   assign read_addr_o  = beat_cnt_q;
   assign read_rdata_o = axi.rdata;
   assign rd_err_o     = rd_err_q;

   assign araddr_full  = {line_addr_q, start_beat_q, {BE_BYTE_W{1'b0}}};
   assign axi.arvalid  = (state_q == ST_ADDR);
   assign axi.araddr   = BE_ADDR_W'(araddr_full);
   assign axi.arlen    = 8'(BEATS - 1);
   assign axi.arsize   = 3'(BE_BYTE_W);
   assign axi.arburst  = (WRAP_EN != 0) ? 2'b10 : 2'b01;
   assign axi.arlock   = 1'b0;
   assign axi.arcache  = 4'b0011;
   assign axi.arprot   = 3'b000;
   assign axi.arqos    = 4'b0000;
   assign axi.arid     = AXI_ID_W'(AXI_ID);
   assign axi.rready   = (state_q == ST_DATA);

endmodule

// File: tb/tb_cache_axi_line_fill.sv
// Bench for cache_axi_line_fill: INCR, WRAP and 64-bit-beat instances driven by directed fills.
module tb_cache_axi_line_fill;

   typedef struct {
      int          d;
      logic [2:0]  addr;
      logic [63:0] data;
   } beat_t;

   typedef struct {
      int          d;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]  rep_valid_s, replace_s, rd_valid_s, rd_err_s, err_clr_s;
   logic [2:0]  arvalid_s, arready_s, rvalid_s, rready_s, rlast_s;
   logic [26:0] rep_addr_s [3];
   logic [2:0]  rep_word_s [3];
   logic [2:0]  rd_addr_s  [3];
   logic [63:0] rd_data_s  [3];
   logic [63:0] rdata_s    [3];
   logic [1:0]  rresp_s    [3];
   logic [31:0] araddr_s   [3];
   logic [7:0]  arlen_s    [3];
   logic [2:0]  arsize_s   [3];
   logic [1:0]  arburst_s  [3];
   logic [12:0] armisc_s   [3];

   int n_checks = 0;
   int n_fail   = 0;
   beat_t exp_beats[$];
   ar_t   exp_ars[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DW = (g == 2) ? 64 : 32;
      localparam int LW = (g == 2) ? 2 : 3;
      logic [LW-1:0] ra;
      logic [DW-1:0] rrd;
      cache_axi_line_fill_if #(.ADDR_W(32), .DATA_W(DW), .ID_W(1)) bus ();

      cache_axi_line_fill #(
         .BE_DATA_W (DW),
         .WRAP_EN   ((g == 1) ? 1 : 0)
      ) dut (
         .clk_i           (clk),
         .reset_i         (rst),
         .replace_valid_i (rep_valid_s[g]),
         .replace_addr_i  (rep_addr_s[g]),
         .replace_word_i  (rep_word_s[g][LW-1:0]),
         .replace_o       (replace_s[g]),
         .read_valid_o    (rd_valid_s[g]),
         .read_addr_o     (ra),
         .read_rdata_o    (rrd),
         .rd_err_o        (rd_err_s[g]),
         .err_clr_i       (err_clr_s[g]),
         .axi             (bus)
      );

      assign rd_addr_s[g]  = 3'(ra);
      assign rd_data_s[g]  = 64'(rrd);
      assign arvalid_s[g]  = bus.arvalid;
      assign araddr_s[g]   = bus.araddr;
      assign arlen_s[g]    = bus.arlen;
      assign arsize_s[g]   = bus.arsize;
      assign arburst_s[g]  = bus.arburst;
      assign armisc_s[g]   = {bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arid};
      assign rready_s[g]   = bus.rready;
      assign bus.arready   = arready_s[g];
      assign bus.rvalid    = rvalid_s[g];
      assign bus.rdata     = rdata_s[g][DW-1:0];
      assign bus.rresp     = rresp_s[g];
      assign bus.rlast     = rlast_s[g];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // scoreboard monitor: every write strobe and AR handshake pops one expectation
   always @(negedge clk) begin
      beat_t b;
      ar_t   a;
      for (int d = 0; d < 3; d++) begin
         if (rd_valid_s[d] === 1'b1) begin
            if (exp_beats.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: dut%0d got read_addr %0d, expected no write", d, rd_addr_s[d]);
            end else begin
               b = exp_beats.pop_front();
               chk("beat_dut", 64'(d), 64'(b.d));
               chk("read_addr", 64'(rd_addr_s[d]), 64'(b.addr));
               chk("read_rdata", rd_data_s[d], b.data);
            end
         end
         if (arvalid_s[d] === 1'b1 && arready_s[d] === 1'b1) begin
            if (exp_ars.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ar: dut%0d got araddr 0x%0h, expected no request", d, araddr_s[d]);
            end else begin
               a = exp_ars.pop_front();
               chk("ar_dut", 64'(d), 64'(a.d));
               chk("araddr", 64'(araddr_s[d]), 64'(a.addr));
               chk("arlen", 64'(arlen_s[d]), 64'(a.len));
               chk("arsize", 64'(arsize_s[d]), 64'(a.size));
               chk("arburst", 64'(arburst_s[d]), 64'(a.burst));
               chk("ar_const", 64'(armisc_s[d]), 64'(13'b0_0011_000_0000_0));
            end
         end
      end
   end

   function automatic logic [63:0] pattern(input int d, input int i);
      return {32'hD00D_0000 + 32'(i), 32'hBEEF_0000 + 32'(d * 256 + i)};
   endfunction

   // one refill: request, AR after 2 wait cycles, nb back-to-back beats;
   // last_i/err_i/clr_i/rst_i pick the beat carrying rlast, SLVERR, err_clr or reset (-1 = none)
   task automatic fill(input int d, input logic [26:0] la, input logic [2:0] w, input int nb,
                       input int last_i, input int err_i, input int clr_i, input int rst_i,
                       input logic [31:0] exp_addr);
      int bpl   = (d == 2) ? 4 : 8;
      int start = (d == 1) ? int'(w) : 0;
      logic [63:0] pat;
      ar_t   a;
      beat_t b;
      a.d = d; a.addr = exp_addr; a.len = 8'(bpl - 1);
      a.size = (d == 2) ? 3'd3 : 3'd2; a.burst = (d == 1) ? 2'b10 : 2'b01;
      exp_ars.push_back(a);
      for (int i = 0; i < nb; i++) begin
         if (i < bpl && (rst_i < 0 || i < rst_i)) begin
            pat = pattern(d, i);
            b.d = d; b.addr = 3'((start + i) % bpl);
            b.data = (d == 2) ? pat : {32'h0, pat[31:0]};
            exp_beats.push_back(b);
         end
      end
      rep_valid_s[d] = 1'b1; rep_addr_s[d] = la; rep_word_s[d] = w;
      @(posedge clk); #1;
      rep_valid_s[d] = 1'b0; rep_addr_s[d] = 27'h7FF_FFFF; rep_word_s[d] = 3'd7;
      chk("ar_latency", 64'(arvalid_s[d]), 64'd1);
      chk("replace_up", 64'(replace_s[d]), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
      arready_s[d] = 1'b1;
      @(posedge clk); #1;
      arready_s[d] = 1'b0;
      chk("rready_up", 64'(rready_s[d]), 64'd1);
      for (int i = 0; i < nb; i++) begin
         rvalid_s[d] = 1'b1;
         rdata_s[d]  = pattern(d, i);
         rlast_s[d]  = (i == last_i);
         rresp_s[d]  = (i == err_i) ? 2'b10 : 2'b00;
         err_clr_s[d] = (i == clr_i);
         if (i == rst_i) begin
            rst = 1'b1;
            #1;
            chk("rst_replace", 64'(replace_s[d]), 64'd0);
            chk("rst_rready", 64'(rready_s[d]), 64'd0);
            chk("rst_arvalid", 64'(arvalid_s[d]), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            rvalid_s[d] = 1'b0; rlast_s[d] = 1'b0;
            return;
         end
         if (i == nb - 1) chk("replace_hold", 64'(replace_s[d]), 64'd1);
         @(posedge clk); #1;
      end
      rvalid_s[d] = 1'b0; rlast_s[d] = 1'b0; rresp_s[d] = 2'b00; err_clr_s[d] = 1'b0;
      chk("replace_fall", 64'(replace_s[d]), 64'd0);
   endtask

   task automatic clear_err(input int d);
      err_clr_s[d] = 1'b1;
      @(posedge clk); #1;
      err_clr_s[d] = 1'b0;
      chk("err_clr", 64'(rd_err_s[d]), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      rep_valid_s = '0; err_clr_s = '0; arready_s = '0; rvalid_s = '0; rlast_s = '0;
      for (int d = 0; d < 3; d++) begin
         rep_addr_s[d] = '0; rep_word_s[d] = '0; rdata_s[d] = '0; rresp_s[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_arvalid", 64'(arvalid_s[d]), 64'd0);
         chk("rst_rready", 64'(rready_s[d]), 64'd0);
         chk("rst_replace", 64'(replace_s[d]), 64'd0);
         chk("rst_read_valid", 64'(rd_valid_s[d]), 64'd0);
         chk("rst_rd_err", 64'(rd_err_s[d]), 64'd0);
         chk("rst_read_addr", 64'(rd_addr_s[d]), 64'd0);
      end

      // INCR fill of line 0x1234: araddr = 0x1234 << 5
      fill(0, 27'h1234, 3'd0, 8, 7, -1, -1, -1, 32'h0002_4680);
      chk("clean_no_err", 64'(rd_err_s[0]), 64'd0);

      // SLVERR on beat 3: all beats still written, error sticky until cleared
      fill(0, 27'h0040, 3'd0, 8, 7, 3, -1, -1, 32'h0000_0800);
      chk("resp_err", 64'(rd_err_s[0]), 64'd1);
      repeat (3) begin @(posedge clk); #1; end
      chk("err_sticky", 64'(rd_err_s[0]), 64'd1);
      clear_err(0);

      // clear coinciding with a new error: error wins
      fill(0, 27'h0041, 3'd0, 8, 7, 3, 3, -1, 32'h0000_0820);
      chk("set_beats_clr", 64'(rd_err_s[0]), 64'd1);
      clear_err(0);

      // early rlast on the 6th beat
      fill(0, 27'h0042, 3'd0, 6, 5, -1, -1, -1, 32'h0000_0840);
      chk("early_last_err", 64'(rd_err_s[0]), 64'd1);
      clear_err(0);

      // overrun: 9 beats, the 9th carries rlast and must not be written
      fill(0, 27'h0043, 3'd0, 9, 8, -1, -1, -1, 32'h0000_0860);
      chk("overrun_err", 64'(rd_err_s[0]), 64'd1);
      clear_err(0);

      // reset on beat 4, then a clean refill
      fill(0, 27'h0044, 3'd0, 8, 7, -1, -1, 4, 32'h0000_0880);
      chk("post_rst_err", 64'(rd_err_s[0]), 64'd0);
      fill(0, 27'h0045, 3'd0, 8, 7, -1, -1, -1, 32'h0000_08A0);
      chk("post_rst_fill", 64'(rd_err_s[0]), 64'd0);

      // WRAP instance, critical beat 5: araddr = (0xABC << 5) | (5 << 2)
      fill(1, 27'h0ABC, 3'd5, 8, 7, -1, -1, -1, 32'h0001_5794);
      chk("wrap_no_err", 64'(rd_err_s[1]), 64'd0);

      // 64-bit beats: 4 beats per line, araddr = 0x55 << 5
      fill(2, 27'h0055, 3'd0, 4, 3, -1, -1, -1, 32'h0000_0AA0);
      chk("wide_no_err", 64'(rd_err_s[2]), 64'd0);

      repeat (2) begin @(posedge clk); #1; end
      chk("beats_drained", 64'(exp_beats.size()), 64'd0);
      chk("ars_drained", 64'(exp_ars.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
